sa_ctrl: RTL
============

SA_CTRL -- requirements
Module: sa_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, giving the array dimension (N x N mac units).
REQ-002 SHALL have parameter W, default 16, giving the element width (bfloat16).
REQ-003 SHALL have parameter LW, default 8, giving the width of the vector-count field.
REQ-004 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  job start request; sampled only in IDLE.
- reuse_w_i  in  1  sampled with start_i; 1 skips weight load.
- len_i  in  LW  number of input vectors in the job; sampled with start_i.
- wgt_valid_i  in  1  weight row beat valid.
- wgt_ready_o  out  1  weight row beat accepted when valid&ready.
- wgt_data_i  in  N*W  one weight row.
- wr_weight_row_o  out  N  one-hot row write enable to the array.
- weight_o  out  N*W  weight row to the array.
- in_valid_i  in  1  input vector valid.
- in_ready_o  out  1  input vector accepted when valid&ready.
- in_data_i  in  N*W  input vector.
- step_o  out  1  array advance strobe.
- data_o  out  N*W  skewed vector to the array right edge.
- out_valid_o  out  1  one result row at the array bottom is valid.
- out_last_o  out  1  qualifies out_valid_o for the final row.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle completion pulse.

Function
REQ-005 FSM states SHALL be IDLE, LOAD_W, STREAM, DRAIN and DONE.
REQ-006 IDLE: on start_i=1, go to LOAD_W if reuse_w_i=0, else STREAM; if len_i=0, go to DONE directly.
REQ-007 LOAD_W: wgt_ready_o=1 and wr_weight_row_o=0. Each accepted beat SHALL drive weight_o=wgt_data_i and the row one-hot on the next cycle, with rows 0..N-1 in order; after N beats go to STREAM.
REQ-008 STREAM: in_ready_o=1. Each accepted vector SHALL cause step_o=1 on the same cycle. With no vector, step_o=0 and array state holds (legal stall). After len accepted vectors, go to DRAIN.
REQ-009 DRAIN: step_o=1 every cycle with zero data inserted, for N_LAT=2N-1 steps, then go to DONE.
REQ-010 Steps SHALL be indexed from 0 per job. The result of vector k (k=0..len-1) SHALL assert out_valid_o in the cycle after step index k+N_LAT-1. out_last_o=1 only for k=len-1.
REQ-011 Skew: lane i of data_o SHALL be lane i of the input delayed by i steps (delay advances only on step_o). Lanes are zero-filled after reset and at job start.
REQ-012 DONE: done_o=1 for exactly one cycle, then IDLE.
REQ-013 start_i SHALL be ignored while busy_o=1. len_i and reuse_w_i SHALL be latched at start and are don't-care afterwards.
REQ-014 Counters SHALL be sized to hold len and N_LAT without wrap. The step counter SHALL be LW+1 bits.

Reset
REQ-015 rst_n=0 SHALL asynchronously force IDLE, clear all counters and the skew delay, and drive every output to 0, including mid-job; no result of an aborted job SHALL appear after reset release.

Configuration
REQ-016 With macro SA_JTAG_HALT_EN defined, ports halt_i (in, 1) and halted_o (out, 1) SHALL exist. While halt_i=1: step_o=0, in_ready_o=0, wgt_ready_o=0, FSM/counters/skew frozen, halted_o=1 from the next cycle. Release SHALL resume with no lost or duplicated beat.
REQ-017 Without SA_JTAG_HALT_EN, halt_i and halted_o SHALL be absent and behaviour is as if halt_i=0.

Structure
REQ-018 Package sa_pkg SHALL hold the FSM state enum and the N_LAT function of N.
REQ-019 The skew delay SHALL be sub-module sa_skew (parameters N, W; inputs clk, rst_n, step, clear, vector in; output vector out).

Verification
REQ-020 N=4, reuse_w_i=0, len=3, all valids held high -> 4 weight beats on rows 0001..1000; 3+7=10 steps; out_valid_o on 3 cycles, last with out_last_o; done_o once.
REQ-021 reuse_w_i=1, len=1 -> no wr_weight_row_o activity; 8 steps; one out_valid_o with out_last_o; done_o once.
REQ-022 len=0 -> DONE on the next cycle; step_o never asserted; done_o once.
REQ-023 in_valid_i toggled 1,0,0,1 during STREAM -> step_o only on accepted beats; lane 3 of data_o equals vector 0 lane 3 after 3 further steps.
REQ-024 rst_n pulsed low in DRAIN -> immediate IDLE, outputs 0, no out_valid_o after release; start_i while busy ignored.
REQ-025 With SA_JTAG_HALT_EN, halt_i=1 for 5 cycles mid-STREAM -> step_o=0 and halted_o=1 throughout; total steps and result count unchanged.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types for the systolic-array sequencer: FSM state encoding and
// the pipeline latency of an N x N array.
package sa_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  // Steps needed after the last input vector until its result leaves the array.
  function automatic int n_lat(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/sa_skew.sv
// Input skew line: lane i of the output is lane i of the input delayed by
// i array steps; the delay only advances on step and is zeroed by clear.
module sa_skew #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           step,
  input  logic           clear,
  input  logic [N*W-1:0] din,
  output logic [N*W-1:0] dout
);

  assign dout[W-1:0] = din[W-1:0];

  for (genvar i = 1; i < N; i++) begin : g_lane
    logic [W-1:0] dly [i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < i; j++) dly[j] <= '0;
      end else if (clear) begin
        for (int j = 0; j < i; j++) dly[j] <= '0;
      end else if (step) begin
        dly[0] <= din[i*W +: W];
        for (int j = 1; j < i; j++) dly[j] <= dly[j-1];
      end
    end

    assign dout[i*W +: W] = dly[i-1];
  end

endmodule

// File: rtl/sa_ctrl.sv
// Job sequencer for an N x N systolic array: weight load, input streaming
// with skew, drain and completion. Optional debug halt under SA_JTAG_HALT_EN.
//
// state    | meaning
// IDLE     | waiting for start_i
// LOAD_W   | accepting N weight rows, written to rows 0..N-1 in order
// STREAM   | accepting len input vectors, one array step per vector
// DRAIN    | N_LAT zero-data steps to flush results out of the array
// DONE     | one-cycle completion pulse
module sa_ctrl
  import sa_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 16,
  parameter int LW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic           reuse_w_i,
  input  logic [LW-1:0]  len_i,
  input  logic           wgt_valid_i,
  output logic           wgt_ready_o,
  input  logic [N*W-1:0] wgt_data_i,
  output logic [N-1:0]   wr_weight_row_o,
  output logic [N*W-1:0] weight_o,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [N*W-1:0] in_data_i,
  output logic           step_o,
  output logic [N*W-1:0] data_o,
  output logic           out_valid_o,
  output logic           out_last_o,
  output logic           busy_o,
  output logic           done_o
`ifdef SA_JTAG_HALT_EN
  ,
  input  logic           halt_i,
  output logic           halted_o
`endif
);

  localparam int NL = n_lat(N);
  localparam int RW = $clog2(N + 1);
  localparam int DW = $clog2(NL + 1);
  localparam logic [N-1:0] ROW0 = 1;

  state_t          state;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   vec_cnt;
  logic [RW-1:0]   wrow_cnt;
  logic [DW-1:0]   drain_cnt;
  logic [LW:0]     step_cnt;
  logic            run;
  logic            clear;
  logic [N*W-1:0]  vin;
  logic [LW+1:0]   sx;
  logic [LW+1:0]   win_end;
  logic            in_win;
  logic            at_last;

`ifdef SA_JTAG_HALT_EN
  assign run = !halt_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_o <= 1'b0;
    else        halted_o <= halt_i;
  end
`else
  assign run = 1'b1;
`endif

  assign busy_o      = (state != S_IDLE);
  assign wgt_ready_o = run && (state == S_LOAD_W);
  assign in_ready_o  = run && (state == S_STREAM);
  assign step_o      = run && (((state == S_STREAM) && in_valid_i) || (state == S_DRAIN));
  assign done_o      = run && (state == S_DONE);
  assign clear       = run && (state == S_IDLE) && start_i;
  assign vin         = ((state == S_STREAM) && step_o) ? in_data_i : '0;

  // Result of vector k leaves the array on step index k+NL-1.
  assign sx      = {1'b0, step_cnt};
  assign win_end = {2'b00, len_q} + (LW+2)'(NL - 1);
  assign in_win  = (sx >= (LW+2)'(NL - 1)) && (sx < win_end);
  assign at_last = (sx == win_end - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      len_q           <= '0;
      vec_cnt         <= '0;
      wrow_cnt        <= '0;
      drain_cnt       <= '0;
      step_cnt        <= '0;
      weight_o        <= '0;
      wr_weight_row_o <= '0;
      out_valid_o     <= 1'b0;
      out_last_o      <= 1'b0;
    end else begin
      wr_weight_row_o <= '0;
      out_valid_o     <= 1'b0;
      out_last_o      <= 1'b0;
      if (run) begin
        if (step_o) begin
          step_cnt    <= step_cnt + 1'b1;
          out_valid_o <= in_win;
          out_last_o  <= at_last;
        end
        unique case (state)
          S_IDLE: begin
            if (start_i) begin
              len_q     <= len_i;
              vec_cnt   <= '0;
              wrow_cnt  <= '0;
              drain_cnt <= '0;
              step_cnt  <= '0;
              if (len_i == '0)    state <= S_DONE;
              else if (reuse_w_i) state <= S_STREAM;
              else                state <= S_LOAD_W;
            end
          end
          S_LOAD_W: begin
            if (wgt_valid_i) begin
              weight_o        <= wgt_data_i;
              wr_weight_row_o <= ROW0 << wrow_cnt;
              wrow_cnt        <= wrow_cnt + 1'b1;
              if (wrow_cnt == RW'(N - 1)) state <= S_STREAM;
            end
          end
          S_STREAM: begin
            if (step_o) begin
              vec_cnt <= vec_cnt + 1'b1;
              if (vec_cnt == len_q - 1'b1) state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            drain_cnt <= drain_cnt + 1'b1;
            if (drain_cnt == DW'(NL - 1)) state <= S_DONE;
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  sa_skew #(.N(N), .W(W)) u_skew (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (step_o),
    .clear (clear),
    .din   (vin),
    .dout  (data_o)
  );

endmodule
